// File: rtl/mem_bank_2rw_mask_param.sv
// ============================================================================
// Module   : mem_bank_2rw_mask_param
// Purpose  : Two-port RW memory bank with lane write masks, registered reads,
//            same-address write arbitration and a reset-time clear sequencer.
//            Optional macro MEM_BANK_WRITE_FORWARD_EN forwards same-cycle
//            writes from the other port into reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bank_2rw_mask_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int LANE_W = 8,
    parameter int LANES  = WIDTH / LANE_W,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    output logic              collision,

    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic [WIDTH-1:0]  RW0_wdata,
    input  logic [LANES-1:0]  RW0_wmask,
    output logic [WIDTH-1:0]  RW0_rdata,
    output logic              RW0_rvalid,

    input  logic              RW1_en,
    input  logic              RW1_wmode,
    input  logic [ADDR_W-1:0] RW1_addr,
    input  logic [WIDTH-1:0]  RW1_wdata,
    input  logic [LANES-1:0]  RW1_wmask,
    output logic [WIDTH-1:0]  RW1_rdata,
    output logic              RW1_rvalid
);

    localparam logic [ADDR_W:0]   c_depth     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_init_busy;
    logic              r_collision;
    logic [WIDTH-1:0]  r_rdata0;
    logic [WIDTH-1:0]  r_rdata1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_ready;
    logic              w_init_we;
    logic              w_in0;
    logic              w_in1;
    logic              w_we0;
    logic              w_we1;
    logic              w_re0;
    logic              w_re1;
    logic [WIDTH-1:0]  w_old0;
    logic [WIDTH-1:0]  w_old1;
    logic [WIDTH-1:0]  w_rd0;
    logic [WIDTH-1:0]  w_rd1;

    // Reset takes priority over both the clear sequencer and port traffic.
    assign w_ready   = (r_state == ST_READY) && !reset;
    assign w_init_we = (r_state == ST_INIT) && !reset;

    assign w_in0 = ({1'b0, RW0_addr} < c_depth);
    assign w_in1 = ({1'b0, RW1_addr} < c_depth);

    assign w_we0 = w_ready && RW0_en && RW0_wmode && w_in0;
    assign w_we1 = w_ready && RW1_en && RW1_wmode && w_in1;
    assign w_re0 = w_ready && RW0_en && !RW0_wmode;
    assign w_re1 = w_ready && RW1_en && !RW1_wmode;

    assign w_old0 = w_in0 ? r_mem[RW0_addr] : '0;
    assign w_old1 = w_in1 ? r_mem[RW1_addr] : '0;

    // Read data: old word, optionally merged with the other port's write.
    always_comb begin
        w_rd0 = w_old0;
        w_rd1 = w_old1;
`ifdef MEM_BANK_WRITE_FORWARD_EN
        for (int k = 0; k < LANES; k++) begin
            if (w_we1 && (RW1_addr == RW0_addr) && RW1_wmask[k])
                w_rd0[k*LANE_W +: LANE_W] = RW1_wdata[k*LANE_W +: LANE_W];
            if (w_we0 && (RW0_addr == RW1_addr) && RW0_wmask[k])
                w_rd1[k*LANE_W +: LANE_W] = RW0_wdata[k*LANE_W +: LANE_W];
        end
`endif
    end

    // Port 1 lanes are written first so port 0 overrides on shared lanes.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[r_ptr] <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (w_we1 && RW1_wmask[k])
                    r_mem[RW1_addr][k*LANE_W +: LANE_W] <= RW1_wdata[k*LANE_W +: LANE_W];
                if (w_we0 && RW0_wmask[k])
                    r_mem[RW0_addr][k*LANE_W +: LANE_W] <= RW0_wdata[k*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_ptr       <= '0;
            r_init_busy <= 1'b1;
            r_collision <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
        end else begin
            r_collision <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == c_last_addr) begin
                        r_state     <= ST_READY;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    r_collision <= w_we0 && w_we1 && (RW0_addr == RW1_addr);
                    if (w_re0) begin
                        r_rdata0  <= w_rd0;
                        r_rvalid0 <= 1'b1;
                    end
                    if (w_re1) begin
                        r_rdata1  <= w_rd1;
                        r_rvalid1 <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_ptr       <= '0;
                    r_init_busy <= 1'b1;
                end
            endcase
        end
    end

    assign init_busy  = r_init_busy;
    assign collision  = r_collision;
    assign RW0_rdata  = r_rdata0;
    assign RW1_rdata  = r_rdata1;
    assign RW0_rvalid = r_rvalid0;
    assign RW1_rvalid = r_rvalid1;

endmodule

`default_nettype wire

// File: tb/tb_mem_bank_2rw_mask_param.sv
// ============================================================================
// Module   : tb_mem_bank_2rw_mask_param
// Purpose  : Self-checking bench for mem_bank_2rw_mask_param (DEPTH 64 and 48).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bank_2rw_mask_param;

    localparam int OP_IDLE = 0;
    localparam int OP_RD   = 1;
    localparam int OP_WR   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: default DEPTH 64
    logic        a_busy, a_col;
    logic        a_en0, a_wm0, a_en1, a_wm1;
    logic [5:0]  a_addr0, a_addr1;
    logic [31:0] a_wd0, a_wd1, a_rd0, a_rd1;
    logic [3:0]  a_mk0, a_mk1;
    logic        a_rv0, a_rv1;

    // Instance B: DEPTH 48 (non-power-of-two)
    logic        b_busy, b_col;
    logic        b_en0, b_wm0, b_en1, b_wm1;
    logic [5:0]  b_addr0, b_addr1;
    logic [31:0] b_wd0, b_wd1, b_rd0, b_rd1;
    logic [3:0]  b_mk0, b_mk1;
    logic        b_rv0, b_rv1;

    mem_bank_2rw_mask_param u_dut_a (
        .clk(clk), .reset(reset), .init_busy(a_busy), .collision(a_col),
        .RW0_en(a_en0), .RW0_wmode(a_wm0), .RW0_addr(a_addr0), .RW0_wdata(a_wd0),
        .RW0_wmask(a_mk0), .RW0_rdata(a_rd0), .RW0_rvalid(a_rv0),
        .RW1_en(a_en1), .RW1_wmode(a_wm1), .RW1_addr(a_addr1), .RW1_wdata(a_wd1),
        .RW1_wmask(a_mk1), .RW1_rdata(a_rd1), .RW1_rvalid(a_rv1)
    );

    mem_bank_2rw_mask_param #(.DEPTH(48)) u_dut_b (
        .clk(clk), .reset(reset), .init_busy(b_busy), .collision(b_col),
        .RW0_en(b_en0), .RW0_wmode(b_wm0), .RW0_addr(b_addr0), .RW0_wdata(b_wd0),
        .RW0_wmask(b_mk0), .RW0_rdata(b_rd0), .RW0_rvalid(b_rv0),
        .RW1_en(b_en1), .RW1_wmode(b_wm1), .RW1_addr(b_addr1), .RW1_wdata(b_wd1),
        .RW1_wmask(b_mk1), .RW1_rdata(b_rd1), .RW1_rvalid(b_rv1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ma [64];
    logic [31:0] mb [48];
    logic [31:0] exp_a0 = '0, exp_a1 = '0, exp_b0 = '0, exp_b1 = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (m[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic step_a(input int op0, input logic [5:0] ad0, input logic [31:0] d0,
                          input logic [3:0] m0, input int op1, input logic [5:0] ad1,
                          input logic [31:0] d1, input logic [3:0] m1);
        logic col;
        a_en0 = (op0 != OP_IDLE); a_wm0 = (op0 == OP_WR);
        a_addr0 = ad0; a_wd0 = d0; a_mk0 = m0;
        a_en1 = (op1 != OP_IDLE); a_wm1 = (op1 == OP_WR);
        a_addr1 = ad1; a_wd1 = d1; a_mk1 = m1;
        if (op0 == OP_RD) begin
            exp_a0 = ma[ad0];
`ifdef MEM_BANK_WRITE_FORWARD_EN
            if (op1 == OP_WR && ad1 == ad0) exp_a0 = merge(exp_a0, d1, m1);
`endif
        end
        if (op1 == OP_RD) begin
            exp_a1 = ma[ad1];
`ifdef MEM_BANK_WRITE_FORWARD_EN
            if (op0 == OP_WR && ad0 == ad1) exp_a1 = merge(exp_a1, d0, m0);
`endif
        end
        col = (op0 == OP_WR) && (op1 == OP_WR) && (ad0 == ad1);
        tick();
        chk("a_rvalid0", 32'(a_rv0), 32'(op0 == OP_RD));
        chk("a_rvalid1", 32'(a_rv1), 32'(op1 == OP_RD));
        chk("a_rdata0", a_rd0, exp_a0);
        chk("a_rdata1", a_rd1, exp_a1);
        chk("a_collision", 32'(a_col), 32'(col));
        if (op1 == OP_WR) ma[ad1] = merge(ma[ad1], d1, m1);
        if (op0 == OP_WR) ma[ad0] = merge(ma[ad0], d0, m0);
        a_en0 = 1'b0; a_en1 = 1'b0;
    endtask

    task automatic step_b(input int op0, input logic [5:0] ad0, input logic [31:0] d0,
                          input int op1, input logic [5:0] ad1, input logic [31:0] d1);
        b_en0 = (op0 != OP_IDLE); b_wm0 = (op0 == OP_WR);
        b_addr0 = ad0; b_wd0 = d0; b_mk0 = 4'hF;
        b_en1 = (op1 != OP_IDLE); b_wm1 = (op1 == OP_WR);
        b_addr1 = ad1; b_wd1 = d1; b_mk1 = 4'hF;
        if (op0 == OP_RD) exp_b0 = (ad0 < 48) ? mb[ad0] : 32'h0;
        if (op1 == OP_RD) exp_b1 = (ad1 < 48) ? mb[ad1] : 32'h0;
        tick();
        chk("b_rvalid0", 32'(b_rv0), 32'(op0 == OP_RD));
        chk("b_rvalid1", 32'(b_rv1), 32'(op1 == OP_RD));
        chk("b_rdata0", b_rd0, exp_b0);
        chk("b_rdata1", b_rd1, exp_b1);
        if (op1 == OP_WR && ad1 < 48) mb[ad1] = d1;
        if (op0 == OP_WR && ad0 < 48) mb[ad0] = d0;
        b_en0 = 1'b0; b_en1 = 1'b0;
    endtask

    initial begin
        int cnt_a, cnt_b, op0, op1;
        logic [5:0] ad0, ad1;
        logic [31:0] exp_fwd;

        {a_en0, a_wm0, a_en1, a_wm1, b_en0, b_wm0, b_en1, b_wm1} = '0;
        {a_addr0, a_addr1, b_addr0, b_addr1} = '0;
        {a_wd0, a_wd1, b_wd0, b_wd1} = '0;
        {a_mk0, a_mk1, b_mk0, b_mk1} = '0;
        for (int i = 0; i < 64; i++) ma[i] = '0;
        for (int i = 0; i < 48; i++) mb[i] = '0;

        // Reset values
        tick(); tick();
        chk("rst_busy", 32'(a_busy), 32'd1);
        chk("rst_rvalid", {30'b0, a_rv0, a_rv1}, 32'd0);
        chk("rst_rdata0", a_rd0, 32'h0);
        chk("rst_collision", 32'(a_col), 32'd0);

        // Requests during INIT are ignored; reset mid-INIT restarts the clear
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                a_en0 = 1'b1; a_wm0 = 1'b1; a_addr0 = 6'd5; a_wd0 = 32'hFFFFFFFF; a_mk0 = 4'hF;
                a_en1 = 1'b1; a_wm1 = 1'b0; a_addr1 = 6'd5;
            end
            tick();
            if (i == 5) begin
                chk("init_no_rvalid", 32'(a_rv1), 32'd0);
                a_en0 = 1'b0; a_en1 = 1'b0;
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 100; i++) begin
            cnt_a += int'(a_busy);
            cnt_b += int'(b_busy);
            tick();
        end
        chk("busy_cycles_64", 32'(cnt_a), 32'd64);
        chk("busy_cycles_48", 32'(cnt_b), 32'd48);

        // Cleared contents, including the address written during INIT
        step_a(OP_RD, 6'd0, 0, 0, OP_RD, 6'd17, 0, 0);
        step_a(OP_RD, 6'd63, 0, 0, OP_RD, 6'd5, 0, 0);
        chk("init_mem5", a_rd1, 32'h0);

        // Lane masks
        step_a(OP_WR, 6'd3, 32'hAABBCCDD, 4'hF, OP_IDLE, 0, 0, 0);
        step_a(OP_IDLE, 0, 0, 0, OP_WR, 6'd3, 32'h11223344, 4'b0101);
        step_a(OP_RD, 6'd3, 0, 0, OP_IDLE, 0, 0, 0);
        chk("mask_merge", a_rd0, 32'hAA22CC44);

        // Double write to same address
        step_a(OP_WR, 6'd9, 32'hFFFFFFFF, 4'b0011, OP_WR, 6'd9, 32'h12345678, 4'b0110);
        chk("collision_pulse", 32'(a_col), 32'd1);
        step_a(OP_RD, 6'd9, 0, 0, OP_IDLE, 0, 0, 0);
        chk("collision_clear", 32'(a_col), 32'd0);
        chk("collision_data", a_rd0, 32'h0034FFFF);

        // Read on one port vs write on the other
        step_a(OP_WR, 6'd7, 32'h01020304, 4'hF, OP_IDLE, 0, 0, 0);
        step_a(OP_WR, 6'd7, 32'hA0B0C0D0, 4'b1000, OP_RD, 6'd7, 0, 0);
`ifdef MEM_BANK_WRITE_FORWARD_EN
        exp_fwd = 32'hA0020304;
`else
        exp_fwd = 32'h01020304;
`endif
        chk("rw_same_addr", a_rd1, exp_fwd);
        step_a(OP_RD, 6'd7, 0, 0, OP_RD, 6'd7, 0, 0);
        chk("dual_read_equal", a_rd0, a_rd1);
        chk("after_write", a_rd0, 32'hA0020304);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            op0 = $urandom_range(0, 2);
            op1 = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0) begin
                ad0 = 6'($urandom_range(0, 3));
                ad1 = 6'($urandom_range(0, 3));
            end else begin
                ad0 = 6'($urandom_range(0, 63));
                ad1 = 6'($urandom_range(0, 63));
            end
            step_a(op0, ad0, $urandom, 4'($urandom_range(0, 15)),
                   op1, ad1, $urandom, 4'($urandom_range(0, 15)));
        end

        // DEPTH=48: fill, then out-of-range write/read
        for (int i = 0; i < 24; i++)
            step_b(OP_WR, 6'(2*i), $urandom, OP_WR, 6'(2*i+1), $urandom);
        step_b(OP_RD, 6'd47, 0, OP_RD, 6'd46, 0);
        step_b(OP_WR, 6'd50, 32'hDEADBEEF, OP_IDLE, 0, 0);
        step_b(OP_RD, 6'd50, 0, OP_IDLE, 0, 0);
        chk("oor_read_zero", b_rd0, 32'h0);
        chk("oor_read_valid", 32'(b_rv0), 32'd1);
        for (int i = 0; i < 48; i++)
            step_b(OP_RD, 6'(i), 0, OP_RD, 6'(47 - i), 0);
        chk("b_no_collision", 32'(b_col), 32'd0);

        // Reset clears the read registers
        reset = 1'b1;
        tick();
        chk("reset_rdata0", a_rd0, 32'h0);
        chk("reset_rdata1", b_rd0, 32'h0);
        chk("reset_busy", 32'(a_busy), 32'd1);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
